// File: rtl/wb_des_regs.sv
// ---------------------------------------------------------------------------
// wb_des_regs
//
// This is a Wishbone classic slave register bank that sits between the
// management-SoC user bus and a DES core. Firmware uses it as follows:
//   1. Load the 64-bit key and the 64-bit data block.
//   2. Pick encrypt or decrypt and write START.
//   3. Poll STATUS, or take an interrupt, until DONE is set.
//   4. Read back the 64-bit result.
// The block drives the start/busy/done handshake with the core and captures
// the core result.
//
// Register window: 32 bytes at BASE_ADR.
//   0x00 CTRL     bit0 START (write-1 pulse, reads 0), bit1 DECRYPT,
//                 bit2 IRQ_EN
//   0x04 STATUS   bit0 BUSY, bit1 DONE (sticky, write-1-to-clear)
//   0x08 KEY_LO   0x0C KEY_HI
//   0x10 DIN_LO   0x14 DIN_HI
//   0x18 DOUT_LO  0x1C DOUT_HI  (read-only)
//
// Optional feature macro: WB_DES_IRQ_EN
//   When it is defined, the irq_o port exists and CTRL.IRQ_EN is writable.
//   When it is not defined, there is no irq_o port, CTRL.IRQ_EN reads 0,
//   and firmware has to poll STATUS.
//
// Ports:
//   wb_clk_i        single clock
//   wb_rstn_i       asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i/adr_i/dat_i   Wishbone classic request
//   wbs_ack_o       registered one-cycle acknowledge
//   wbs_dat_o       registered read data (0 when not acking)
//   des_key_o       key to the core
//   des_din_o       input block to the core
//   des_decrypt_o   1 = decrypt, 0 = encrypt
//   des_start_o     one-cycle start pulse
//   des_done_i      one-cycle completion pulse from the core
//   des_dout_i      core result, valid with des_done_i
//   irq_o           level interrupt DONE & IRQ_EN (WB_DES_IRQ_EN only)
// ---------------------------------------------------------------------------
module wb_des_regs #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [63:0] des_key_o,
  output logic [63:0] des_din_o,
  output logic        des_decrypt_o,
  output logic        des_start_o,
  input  logic        des_done_i,
  input  logic [63:0] des_dout_i
`ifdef WB_DES_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic        start_nxt;
  logic        hit, acc, wr, rd;
  logic [2:0]  off;
  logic        busy;
  logic        ctrl_wr, status_wr;
  logic        core_done;
  logic        done_q;
  logic        irq_en;
  logic [63:0] dout_q;
  logic [31:0] rdata;
  logic        unused_adr;

  // Per-byte merge of a write into an existing 32-bit register word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // A transfer is accepted only when the slave is not already acking it.
  // This means a strobe that is still held during the ack cycle is not
  // accepted a second time in that cycle.
  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign acc        = hit & ~wbs_ack_o;
  assign wr         = acc & wbs_we_i;
  assign rd         = acc & ~wbs_we_i;
  assign off        = wbs_adr_i[4:2];
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  assign busy      = (state == RUN);
  assign ctrl_wr   = wr & (off == 3'd0) & wbs_sel_i[0];
  assign status_wr = wr & (off == 3'd1) & wbs_sel_i[0];
  // The core's done pulse only counts while a run is in progress.
  assign core_done = busy & des_done_i;

  // FSM state register and start pulse.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state       <= IDLE;
      des_start_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      des_start_o <= start_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_wr && wbs_dat_i[0]) begin
          state_nxt = RUN;
          start_nxt = 1'b1;
        end
      end
      RUN: begin
        if (des_done_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers. They are frozen while a run is in progress, so the
  // core sees stable inputs from the start write until completion.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      des_key_o     <= '0;
      des_din_o     <= '0;
      des_decrypt_o <= 1'b0;
    end else if (wr && !busy) begin
      case (off)
        3'd0: if (wbs_sel_i[0]) des_decrypt_o <= wbs_dat_i[1];
        3'd2: des_key_o[31:0]  <= byte_merge(des_key_o[31:0],  wbs_dat_i, wbs_sel_i);
        3'd3: des_key_o[63:32] <= byte_merge(des_key_o[63:32], wbs_dat_i, wbs_sel_i);
        3'd4: des_din_o[31:0]  <= byte_merge(des_din_o[31:0],  wbs_dat_i, wbs_sel_i);
        3'd5: des_din_o[63:32] <= byte_merge(des_din_o[63:32], wbs_dat_i, wbs_sel_i);
        default: ;
      endcase
    end
  end

  // Result capture and sticky DONE. When a set and a clear happen in the
  // same cycle, the completion (set) takes priority over the W1C.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (core_done) begin
        dout_q <= des_dout_i;
        done_q <= 1'b1;
      end else if (status_wr && wbs_dat_i[1]) begin
        done_q <= 1'b0;
      end
    end
  end

`ifdef WB_DES_IRQ_EN
  // IRQ_EN is not an operand, so it stays writable during a run.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en <= wbs_dat_i[2];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= done_q & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      3'd0: rdata = {29'd0, irq_en, des_decrypt_o, 1'b0};
      3'd1: rdata = {30'd0, done_q, busy};
      3'd2: rdata = des_key_o[31:0];
      3'd3: rdata = des_key_o[63:32];
      3'd4: rdata = des_din_o[31:0];
      3'd5: rdata = des_din_o[63:32];
      3'd6: rdata = dout_q[31:0];
      3'd7: rdata = dout_q[63:32];
      default: rdata = '0;
    endcase
  end

  // Bus response: ack and read data are registered together.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata : 32'd0;
    end
  end

endmodule
